// File: rtl/dffram_lsu_bridge_if.sv
// Core-side data-memory request/response channel for the DFFRAM load/store bridge.
// master = core (issues requests), slave = bridge.
interface dffram_lsu_bridge_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dffram_lsu_bridge.sv
// Load/store bridge from the core request channel to a 32-bit byte-writable DFFRAM.
// One request at a time: alignment check, RAM access, lane-extracted load response.
module dffram_lsu_bridge #(
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic               CLK,
    input  logic               RST,
    dffram_lsu_bridge_if.slave bus,
    output logic               ram_en,
    output logic [3:0]         ram_we,
    output logic [ADDR_W-1:0]  ram_a,
    output logic [31:0]        ram_di,
    input  logic [31:0]        ram_do
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // READ_LAT is 1..4, so the remaining-cycle count fits in two bits
    localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

    state_t      state;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [1:0]  cnt;

    logic        req_err;
    logic [3:0]  st_we;
    logic [31:0] st_di;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        req_err = 1'b0;
        st_we   = '0;
        st_di   = bus.req_wdata;
        case (bus.req_size)
            2'd0: begin
                st_we = 4'b0001 << bus.req_addr[1:0];
                st_di = {4{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                req_err = bus.req_addr[0];
                st_we   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                st_di   = {2{bus.req_wdata[15:0]}};
            end
            2'd2: begin
                req_err = (bus.req_addr[1:0] != 2'b00);
                st_we   = 4'b1111;
            end
            default: req_err = 1'b1;
        endcase
        if (!bus.req_we) begin
            st_we = '0;
        end
    end

    always_comb begin
        ld_byte = ram_do[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? ram_do[31:16] : ram_do[15:0];
        case (size_q)
            2'd0:    ld_data = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
            2'd1:    ld_data = {{16{ld_half[15] & ~uns_q}}, ld_half};
            default: ld_data = ram_do;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            ram_en        <= 1'b0;
            ram_we        <= '0;
            ram_a         <= '0;
            ram_di        <= '0;
            we_q          <= 1'b0;
            uns_q         <= 1'b0;
            size_q        <= '0;
            lane_q        <= '0;
            cnt           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        we_q          <= bus.req_we;
                        uns_q         <= bus.req_unsigned;
                        size_q        <= bus.req_size;
                        lane_q        <= bus.req_addr[1:0];
                        if (req_err) begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                        end else begin
                            state  <= ACCESS;
                            ram_en <= 1'b1;
                            ram_we <= st_we;
                            ram_a  <= bus.req_addr[ADDR_W+1:2];
                            cnt    <= CNT_INIT;
                            // ram_di doubles as the latched, lane-replicated store data
                            if (bus.req_we) begin
                                ram_di <= st_di;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (we_q || cnt == '0) begin
                        state         <= RESP;
                        ram_en        <= 1'b0;
                        ram_we        <= '0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= we_q ? '0 : ld_data;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dffram_lsu_bridge.sv
// Directed bench for dffram_lsu_bridge with a behavioural byte-writable DFFRAM model.
module tb_dffram_lsu_bridge;

    localparam int AW = 8;
    localparam int RL = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_a;
    logic [31:0]   ram_di;
    logic [31:0]   ram_do;
    logic [31:0]   mem [256];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    int unsigned en_cycles;
    int unsigned lat;
    logic [3:0]  we_seen;
    logic [7:0]  a_seen;
    logic [31:0] di_seen;
    logic [31:0] got_rdata;
    logic        got_err;
    logic        got_resp;

    dffram_lsu_bridge_if #(.ADDR_W(AW)) bus ();

    dffram_lsu_bridge #(.ADDR_W(AW), .READ_LAT(RL)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .bus    (bus),
        .ram_en (ram_en),
        .ram_we (ram_we),
        .ram_a  (ram_a),
        .ram_di (ram_di),
        .ram_do (ram_do)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (ram_en) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_we[i]) mem[ram_a][8*i +: 8] <= ram_di[8*i +: 8];
            end
        end
    end
    assign ram_do = mem[ram_a];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // Issues one request from a negedge with rsp_ready high; returns at the negedge after the handshake.
    task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                        input logic [9:0] addr, input logic [31:0] wdata);
        en_cycles = 0; lat = 0; we_seen = '0; a_seen = '0; di_seen = '0;
        got_rdata = '0; got_err = 1'b0; got_resp = 1'b0;
        check("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
        bus.rsp_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.req_valid = 1'b0;
        for (int n = 0; n < 20 && !got_resp; n++) begin
            we_seen |= ram_we;
            if (ram_en) begin
                en_cycles++; a_seen = ram_a; di_seen = ram_di;
            end
            if (bus.rsp_valid) begin
                got_resp = 1'b1; got_rdata = bus.rsp_rdata; got_err = bus.rsp_err; lat = n;
            end else begin
                @(negedge CLK);
            end
        end
        check("rsp_timeout", {31'b0, got_resp}, 32'd1);
        @(negedge CLK);
        check("post_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        // reset values
        @(posedge CLK);
        @(negedge CLK);
        check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_rdata", bus.rsp_rdata, 32'd0);
        check("rst_err", {31'b0, bus.rsp_err}, 32'd0);
        check("rst_en", {31'b0, ram_en}, 32'd0);
        check("rst_we", {28'b0, ram_we}, 32'd0);
        check("rst_a", {24'b0, ram_a}, 32'd0);
        check("rst_di", ram_di, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);

        // 1: word store / load
        xact(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF);
        check("sw_en_cycles", en_cycles, 32'd1);
        check("sw_we", {28'b0, we_seen}, 32'hF);
        check("sw_a", {24'b0, a_seen}, 32'h04);
        check("sw_di", di_seen, 32'hDEADBEEF);
        check("sw_lat", lat, 32'd1);
        check("sw_rdata", got_rdata, 32'd0);
        check("sw_err", {31'b0, got_err}, 32'd0);
        xact(1'b0, 2'd2, 1'b0, 10'h010, 32'h0);
        check("lw_rdata", got_rdata, 32'hDEADBEEF);
        check("lw_err", {31'b0, got_err}, 32'd0);
        check("lw_en_cycles", en_cycles, RL);
        check("lw_we", {28'b0, we_seen}, 32'h0);
        check("lw_lat", lat, RL);

        // 2: byte store and signed/unsigned byte loads
        xact(1'b1, 2'd0, 1'b0, 10'h013, 32'h00000080);
        check("sb_we", {28'b0, we_seen}, 32'h8);
        check("sb_di", di_seen, 32'h80808080);
        check("sb_a", {24'b0, a_seen}, 32'h04);
        xact(1'b0, 2'd0, 1'b0, 10'h013, 32'h0);
        check("lb_s_013", got_rdata, 32'hFFFFFF80);
        xact(1'b0, 2'd0, 1'b1, 10'h013, 32'h0);
        check("lb_u_013", got_rdata, 32'h00000080);
        xact(1'b0, 2'd0, 1'b1, 10'h012, 32'h0);
        check("lb_u_012", got_rdata, 32'h000000AD);
        xact(1'b0, 2'd0, 1'b0, 10'h010, 32'h0);
        check("lb_s_010", got_rdata, 32'hFFFFFFEF);

        // 3: half store into upper half, lower half preserved
        xact(1'b1, 2'd2, 1'b0, 10'h020, 32'h11223344);
        xact(1'b1, 2'd1, 1'b0, 10'h022, 32'h00008001);
        check("sh_we", {28'b0, we_seen}, 32'hC);
        check("sh_di", di_seen, 32'h80018001);
        check("sh_a", {24'b0, a_seen}, 32'h08);
        xact(1'b0, 2'd1, 1'b0, 10'h022, 32'h0);
        check("lh_s_022", got_rdata, 32'hFFFF8001);
        xact(1'b0, 2'd1, 1'b1, 10'h022, 32'h0);
        check("lh_u_022", got_rdata, 32'h00008001);
        xact(1'b0, 2'd1, 1'b0, 10'h020, 32'h0);
        check("lh_s_020", got_rdata, 32'h00003344);
        xact(1'b0, 2'd2, 1'b0, 10'h020, 32'h0);
        check("lw_020", got_rdata, 32'h80013344);
        xact(1'b1, 2'd1, 1'b0, 10'h020, 32'h0000ABCD);
        check("sh_lo_we", {28'b0, we_seen}, 32'h3);
        check("sh_lo_di", di_seen, 32'hABCDABCD);

        // 4: error requests never touch the RAM
        xact(1'b0, 2'd2, 1'b0, 10'h011, 32'h0);
        check("err_lw_err", {31'b0, got_err}, 32'd1);
        check("err_lw_rdata", got_rdata, 32'd0);
        check("err_lw_en", en_cycles, 32'd0);
        check("err_lw_lat", lat, 32'd0);
        xact(1'b0, 2'd1, 1'b0, 10'h001, 32'h0);
        check("err_lh_err", {31'b0, got_err}, 32'd1);
        check("err_lh_en", en_cycles, 32'd0);
        xact(1'b0, 2'd3, 1'b0, 10'h000, 32'h0);
        check("err_sz3_err", {31'b0, got_err}, 32'd1);
        check("err_sz3_en", en_cycles, 32'd0);
        xact(1'b1, 2'd2, 1'b0, 10'h012, 32'h12345678);
        check("err_sw_err", {31'b0, got_err}, 32'd1);
        check("err_sw_we", {28'b0, we_seen}, 32'h0);
        check("err_sw_en", en_cycles, 32'd0);
        xact(1'b0, 2'd2, 1'b0, 10'h010, 32'h0);
        check("after_err_rdata", got_rdata, 32'h80ADBEEF);
        check("after_err_err", {31'b0, got_err}, 32'd0);

        // 5: backpressure
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0; bus.req_addr = 10'h020; bus.rsp_ready = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        bus.req_valid = 1'b0;
        for (int n = 0; n < 20 && !bus.rsp_valid; n++) @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'b0, bus.rsp_valid}, 32'd1);
            check("bp_rdata", bus.rsp_rdata, 32'h8001ABCD);
            check("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
            @(negedge CLK);
        end
        bus.rsp_ready = 1'b1;
        @(negedge CLK);
        check("bp_done_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("bp_done_ready", {31'b0, bus.req_ready}, 32'd1);

        // 6a: reset during store ACCESS
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
        bus.req_addr = 10'h040; bus.req_wdata = 32'h55AA55AA;
        @(posedge CLK);
        @(negedge CLK);
        bus.req_valid = 1'b0;
        check("rs_in_access", {31'b0, ram_en}, 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("rs_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rs_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rs_we", {28'b0, ram_we}, 32'd0);
        check("rs_en", {31'b0, ram_en}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("rs_quiet_valid", {31'b0, bus.rsp_valid}, 32'd0);
            check("rs_quiet_we", {28'b0, ram_we}, 32'd0);
        end

        // 6b: reset during RESP drops the response
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
        bus.req_addr = 10'h010; bus.rsp_ready = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        bus.req_valid = 1'b0;
        for (int n = 0; n < 20 && !bus.rsp_valid; n++) @(negedge CLK);
        check("rr_in_resp", {31'b0, bus.rsp_valid}, 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        bus.rsp_ready = 1'b1;
        check("rr_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rr_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rr_rdata", bus.rsp_rdata, 32'd0);
        check("rr_we", {28'b0, ram_we}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("rr_quiet_valid", {31'b0, bus.rsp_valid}, 32'd0);
        end
        xact(1'b0, 2'd2, 1'b0, 10'h010, 32'h0);
        check("post_rst_lw", got_rdata, 32'h80ADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
